// File: rtl/divu_hilo_ctrl_pkg.sv
// Shared constants for the DIVU sequencer and HI/LO pair.
// DIV_ZERO_FAST_EN: see divu_hilo_ctrl.sv.
package divu_hilo_ctrl_pkg;

  localparam int XLEN         = 32;
  localparam int DEF_ITER_CNT = 33;
  localparam int CNT_W        = 6;

  localparam logic [5:0] DIV_NOP  = 6'b000000;
  localparam logic [5:0] DIV_DIVU = 6'b011011;
  localparam logic [5:0] DIV_OUT  = 6'b111111;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_ITER    = 3'd2;
  localparam state_t S_OUT     = 3'd3;
  localparam state_t S_CAPTURE = 3'd4;

endpackage

// File: rtl/divu_hilo_ctrl_if.sv
// Control/data bundle between the DIVU sequencer and the
// iterative divider.
interface divu_hilo_ctrl_if
  import divu_hilo_ctrl_pkg::*;
();

  logic              div_enable;
  logic [5:0]        div_signal;
  logic [XLEN-1:0]   div_dataA;
  logic [XLEN-1:0]   div_dataB;
  logic [2*XLEN-1:0] div_result;

  modport master (
    output div_enable,
    output div_signal,
    output div_dataA,
    output div_dataB,
    input  div_result
  );

  modport slave (
    input  div_enable,
    input  div_signal,
    input  div_dataA,
    input  div_dataB,
    output div_result
  );

endinterface

// File: rtl/divu_hilo_ctrl_div_iter_counter.sv
// Iteration counter for the divider ITER phase:
// clear, count-enable and terminal-count flag.
module div_iter_counter
  import divu_hilo_ctrl_pkg::*;
#(
  parameter int LAST = DEF_ITER_CNT - 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;

  assign tc = (cnt_q == CNT_W'(LAST));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/divu_hilo_ctrl.sv
// DIVU sequencer + HI/LO registers in front of the iterative divider.
// Optional `DIV_ZERO_FAST_EN: divisor 0 bypasses the divider.
module divu_hilo_ctrl
  import divu_hilo_ctrl_pkg::*;
#(
  parameter int ITER_CNT = DEF_ITER_CNT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            abort,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  divu_hilo_ctrl_if.master div,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] opb_q;
  logic            tc;
  logic            zf_go;
  logic            accept;
  logic            cap;
  logic [XLEN-1:0] cap_hi;
  logic [XLEN-1:0] cap_lo;

  logic st_idle;
  logic st_load;
  logic st_iter;
  logic st_out;
  logic st_cap;

  assign st_idle = (state_q == S_IDLE);
  assign st_load = (state_q == S_LOAD);
  assign st_iter = (state_q == S_ITER);
  assign st_out  = (state_q == S_OUT);
  assign st_cap  = (state_q == S_CAPTURE);

  assign accept = st_idle & start & ~abort;
  assign cap    = st_cap & ~abort;

  assign busy = ~st_idle;
  assign done = cap;

  assign div.div_enable = st_load;
  assign div.div_dataA  = opa_q;
  assign div.div_dataB  = opb_q;

  always_comb begin
    div.div_signal = DIV_NOP;
    unique case (1'b1)
      st_iter: div.div_signal = DIV_DIVU;
      st_out:  div.div_signal = DIV_OUT;
      default: ;
    endcase
  end

`ifdef DIV_ZERO_FAST_EN
  logic zf_q;

  assign zf_go  = (op_b == '0);
  assign cap_lo = zf_q ? '1 : div.div_result[2*XLEN-1:XLEN];
  assign cap_hi = zf_q ? opa_q : div.div_result[XLEN-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zf_q <= 1'b0;
    end else if (accept) begin
      zf_q <= zf_go;
    end
  end
`else
  assign zf_go  = 1'b0;
  assign cap_lo = div.div_result[2*XLEN-1:XLEN];
  assign cap_hi = div.div_result[XLEN-1:0];
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = zf_go ? S_CAPTURE : S_LOAD;
      S_LOAD:    state_d = S_ITER;
      S_ITER:    if (tc) state_d = S_OUT;
      S_OUT:     state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    // a flush always wins, including over a same-cycle start
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opa_q <= '0;
      opb_q <= '0;
    end else if (accept) begin
      opa_q <= op_a;
      opb_q <= op_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (cap) begin
      hi <= cap_hi;
      lo <= cap_lo;
    end else if (st_idle) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

  div_iter_counter #(
    .LAST (ITER_CNT - 1)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (~st_iter | abort),
    .en    (st_iter),
    .tc    (tc)
  );

endmodule

// File: tb/tb_divu_hilo_ctrl.sv
// Directed bench for divu_hilo_ctrl with a behavioural
// restoring-divider stand-in on the divider bus.
module tb_divu_hilo_ctrl;

  localparam logic [5:0] C_NOP  = 6'b000000;
  localparam logic [5:0] C_DIVU = 6'b011011;
  localparam logic [5:0] C_OUT  = 6'b111111;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZBUSY = 1;
`else
  localparam int ZBUSY = 36;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        abort = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  divu_hilo_ctrl_if dif ();

  divu_hilo_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .abort (abort),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .div   (dif.master),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  logic [31:0] ma = '0;
  logic [31:0] mb = '0;

  initial dif.div_result = '0;

  always @(posedge clk) begin
    if (dif.div_enable) begin
      ma <= dif.div_dataA;
      mb <= dif.div_dataB;
    end
    if (dif.div_signal == C_OUT) begin
      if (mb == 32'd0) dif.div_result <= {32'hFFFF_FFFF, ma};
      else dif.div_result <= {ma / mb, ma % mb};
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_div(input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_busy, input int lo_poke,
                         input int abort_at,
                         input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int nb, ni, no, ne, dn, fi, oa, g;
    nb = 0; ni = 0; no = 0; ne = 0;
    dn = 0; fi = 0; oa = 0; g = 0;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    while (busy && g < 100) begin
      g++;
      nb++;
      if (dif.div_signal == C_DIVU) begin
        ni++;
        if (fi == 0) fi = nb;
      end
      if (dif.div_signal == C_OUT) begin
        no++;
        oa = nb;
      end
      if (dif.div_enable) ne++;
      if (done) dn = nb;
      lo_we = (nb == lo_poke);
      wdata = 32'hAAAA_5555;
      abort = (nb == abort_at);
      @(negedge clk);
      lo_we = 1'b0;
      abort = 1'b0;
    end
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    chk({tag, ".busy"}, 64'(nb), 64'(exp_busy));
    chk({tag, ".done"}, 64'(dn), 64'(abort_at != 0 ? 0 : exp_busy));
    if (abort_at == 0) begin
      chk({tag, ".iters"}, 64'(ni), 64'(exp_busy > 1 ? 33 : 0));
      chk({tag, ".outs"}, 64'(no), 64'(exp_busy > 1 ? 1 : 0));
      chk({tag, ".loads"}, 64'(ne), 64'(exp_busy > 1 ? 1 : 0));
      if (exp_busy > 1) begin
        chk({tag, ".iter1"}, 64'(fi), 64'd2);
        chk({tag, ".outat"}, 64'(oa), 64'd35);
      end
    end
    chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".en"}, 64'(dif.div_enable), 64'd0);
    chk({tag, ".sig"}, 64'(dif.div_signal), 64'(C_NOP));
    chk({tag, ".da"}, 64'(dif.div_dataA), 64'd0);
    chk({tag, ".db"}, 64'(dif.div_dataB), 64'd0);
    chk({tag, ".hi"}, 64'(hi), 64'd0);
    chk({tag, ".lo"}, 64'(lo), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;

    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt.hi", 64'(hi), 64'h1234_5678);
    chk("mt.lo", 64'(lo), 64'h1234_5678);

    start = 1'b1; op_a = 32'd50; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("mid.sig", 64'(dif.div_signal), 64'(C_DIVU));
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;

    run_div("d100_7", 32'd100, 32'd7, 36, 0, 0, 32'd14, 32'd2);
    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 36, 0, 0,
            32'hFFFF_FFFF, 32'd0);
    run_div("dz5", 32'd5, 32'd0, ZBUSY, 0, 0, 32'hFFFF_FFFF, 32'd5);
    run_div("lowe", 32'd1000, 32'd33, 36, 5, 0, 32'd30, 32'd10);

    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", 64'(hi), 64'hDEAD_BEEF);
    run_div("abrt", 32'd77, 32'd3, 10, 0, 10, 32'd30, 32'hDEAD_BEEF);

    @(negedge clk);
    start = 1'b1; abort = 1'b1; op_a = 32'd9; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa.busy", 64'(busy), 64'd0);

    run_div("again", 32'd100, 32'd7, 36, 0, 0, 32'd14, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divu_hilo_ctrl.md
# divu_hilo_ctrl

Sequencer and HI/LO register pair sitting directly upstream of the iterative restoring divider in the execute stage. Accepts a DIVU request from the pipeline, drives the divider's load/iterate/output controls for the fixed iteration count, captures the 64-bit result into HI (remainder) and LO (quotient), and stalls the pipeline while busy. Also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
- ITER_CNT, 33, divider iteration cycles per DIVU (32-bit dividend against divisor pre-shifted by 32)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a DIVU; sampled only in IDLE
- op_a  input  32  dividend (rs)
- op_b  input  32  divisor (rt)
- abort  input  1  pipeline flush; cancels an in-flight divide
- hi_we, lo_we  input  1 each  MTHI / MTLO write strobes
- wdata  input  32  MTHI/MTLO data
- div_enable  output  1  divider load strobe
- div_signal  output  6  divider command: 6'b011011 DIVU iterate, 6'b111111 OUT, 6'b000000 idle
- div_dataA, div_dataB  output  32 each  operands to divider, held stable from LOAD through OUT
- div_result  input  64  divider output: [63:32] quotient, [31:0] remainder
- busy  output  1  stall request, high in every non-IDLE state
- done  output  1  one-cycle pulse in CAPTURE
- hi, lo  output  32 each  architectural HI/LO registers

## Operation
- States: IDLE → LOAD → ITER → OUT → CAPTURE → IDLE.
- IDLE: div_signal=000000, div_enable=0. start=1 latches op_a/op_b into operand registers, goes to LOAD.
- LOAD (1 cycle): div_enable=1, div_signal=000000.
- ITER (ITER_CNT cycles): div_enable=0, div_signal=DIVU; 6-bit counter from 0 to ITER_CNT-1, exit on last count.
- OUT (1 cycle): div_signal=OUT.
- CAPTURE (1 cycle): div_signal=000000; at the closing edge lo←div_result[63:32], hi←div_result[31:0]; done=1.
- abort in any non-IDLE state: next state IDLE, counter cleared, hi/lo unchanged, no done.
- abort and start together in IDLE: abort wins, request dropped.
- hi_we/lo_we honoured only in IDLE; ignored while busy. If hi_we/lo_we and start arrive in the same IDLE cycle, the write is applied and the divide proceeds (its CAPTURE overwrites later).
- Divide by zero without the fast path: run normally; the divider yields quotient 32'hFFFFFFFF, remainder op_a.

## Timing
- Reset (async, active-low): state IDLE, counter 0, hi=lo=0, operand registers 0, div_enable=0, div_signal=000000, busy=0, done=0.
- All outputs registered or decoded from state; no combinational path from start to div_* outputs.
- start accepted at edge 0; LOAD during cycle 1; ITER cycles 2..34; OUT cycle 35; CAPTURE cycle 36; hi/lo valid after edge 36. Total 36 cycles (ITER_CNT+3).
- busy rises the cycle after start is accepted and falls the cycle after CAPTURE; new start accepted the first IDLE cycle after.
- MTHI/MTLO: hi/lo update at the edge where the strobe is sampled.

## Configuration
- DIV_ZERO_FAST_EN defined: start with op_b==0 goes directly IDLE→CAPTURE, skipping the divider; CAPTURE writes lo=32'hFFFFFFFF, hi=op_a; latency 2 cycles; divider control lines stay idle.
- Undefined: op_b==0 takes the full 36-cycle path with identical HI/LO results.

## Structure
- Shared package: divider command constants (DIVU 6'b011011, OUT 6'b111111, NOP 6'b000000), state enum, default ITER_CNT.
- One sub-module, div_iter_counter: load/enable/terminal-count counter used by ITER; FSM and HI/LO stay in the top.

## Test plan
- Reset mid-ITER (cycle 20) → all outputs at reset values immediately; hi=lo=0.
- start op_a=100, op_b=7 → busy 36 cycles, done at cycle 36, lo=14, hi=2; div_signal sequence 000000, DIVU×33, OUT, 000000.
- start op_a=32'hFFFFFFFF, op_b=1 → lo=32'hFFFFFFFF, hi=0.
- op_b=0, op_a=5 → lo=32'hFFFFFFFF, hi=5; latency 2 with DIV_ZERO_FAST_EN, 36 without.
- hi_we wdata=32'hDEAD_BEEF in IDLE then abort at cycle 10 of a divide → hi stays DEADBEEF, no done, next start accepted.
- lo_we during busy → ignored; CAPTURE result lands in lo.
